// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID definitions: opcode/funct constants, halt encoding, op-class codes.
package if_id_queue_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [5:0] OPC_R_OP  = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Op-class codes; 0 means bubble or unrecognised instruction.
  typedef enum int {
    OP_NONE  = 0,
    OP_HALT  = 1,
    OP_LW    = 2,
    OP_SW    = 3,
    OP_BEQ   = 4,
    OP_BNE   = 5,
    OP_ADDI  = 6,
    OP_ADDIU = 7,
    OP_ADD   = 8,
    OP_ADDU  = 9,
    OP_SUBU  = 10,
    OP_SLL   = 11,
    OP_SLTU  = 12
  } op_class_e;

endpackage

// File: rtl/ifid_op_decode.sv
// Combinational decode of one instruction into op class and source-register fields.
module ifid_op_decode
  import if_id_queue_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [31:0]    instr,
  output logic [OPW-1:0] op,
  output logic [4:0]     rs,
  output logic [4:0]     rt
);

  assign rs = instr[25:21];
  assign rt = instr[20:16];

  // Halt is matched on the full word first; otherwise classify by opcode, then funct.
  always_comb begin
    op = '0;
    if (instr == HALT_INSTR) begin
      op = OPW'(OP_HALT);
    end else begin
      case (instr[31:26])
        OPC_LW:    op = OPW'(OP_LW);
        OPC_SW:    op = OPW'(OP_SW);
        OPC_BEQ:   op = OPW'(OP_BEQ);
        OPC_BNE:   op = OPW'(OP_BNE);
        OPC_ADDI:  op = OPW'(OP_ADDI);
        OPC_ADDIU: op = OPW'(OP_ADDIU);
        OPC_R_OP: begin
          case (instr[5:0])
            FN_ADD:  op = OPW'(OP_ADD);
            FN_ADDU: op = OPW'(OP_ADDU);
            FN_SUBU: op = OPW'(OP_SUBU);
            FN_SLL:  op = OPW'(OP_SLL);
            FN_SLTU: op = OPW'(OP_SLTU);
            default: op = '0;
          endcase
        end
        default: op = '0;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO with valid/ready, flush and sticky halt.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int OPW   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [XLEN-1:0]            if_instr,
  input  logic [XLEN-1:0]            if_npc,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [XLEN-1:0]            id_instr,
  output logic [XLEN-1:0]            id_npc,
  output logic [OPW-1:0]             id_op,
  output logic [4:0]                 id_rs,
  output logic [4:0]                 id_rt,
  output logic                       halt_seen,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] npc_q   [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            halt_q, halt_d;
  logic            push, pop;
  logic [XLEN-1:0] head_instr;
  logic [OPW-1:0]  dec_op;
  logic [4:0]      dec_rs, dec_rt;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered state: a full queue never accepts, even while popping.
  assign if_ready = (count_q < CW'(DEPTH)) & ~halt_q;
  assign id_valid = (count_q != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  // Next-state for pointers, occupancy and halt flag; flush overrides push/pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    halt_d  = halt_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      halt_d  = 1'b0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      if (push && (if_instr == XLEN'(HALT_INSTR))) halt_d = 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // State and storage registers; reset wins over flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        npc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      halt_q  <= halt_d;
      if (push && !flush) begin
        instr_q[tail_q] <= if_instr;
        npc_q[tail_q]   <= if_npc;
      end
    end
  end

  assign head_instr = instr_q[head_q];

  ifid_op_decode #(.OPW(OPW)) u_dec (
    .instr (head_instr[31:0]),
    .op    (dec_op),
    .rs    (dec_rs),
    .rt    (dec_rt)
  );

  // Head outputs read storage only; an empty queue presents an all-zero bubble.
  assign id_instr  = id_valid ? head_instr    : '0;
  assign id_npc    = id_valid ? npc_q[head_q] : '0;
  assign id_op     = id_valid ? dec_op        : '0;
  assign id_rs     = id_valid ? dec_rs        : '0;
  assign id_rt     = id_valid ? dec_rt        : '0;
  assign halt_seen = halt_q;
  assign count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: DEPTH=2 instance for function, DEPTH=3 for wrap order.
module tb_if_id_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // DEPTH=2 instance signals
  logic        a_reset, a_if_valid, a_if_ready, a_flush, a_id_ready, a_id_valid, a_halt;
  logic [31:0] a_if_instr, a_if_npc, a_id_instr, a_id_npc;
  logic [3:0]  a_id_op;
  logic [4:0]  a_id_rs, a_id_rt;
  logic [1:0]  a_count;

  // DEPTH=3 instance signals
  logic        b_reset, b_if_valid, b_if_ready, b_flush, b_id_ready, b_id_valid, b_halt;
  logic [31:0] b_if_instr, b_if_npc, b_id_instr, b_id_npc;
  logic [3:0]  b_id_op;
  logic [4:0]  b_id_rs, b_id_rt;
  logic [1:0]  b_count;

  if_id_queue #(.XLEN(32), .DEPTH(2), .OPW(4)) dut_a (
    .clk(clk), .reset(a_reset), .if_valid(a_if_valid), .if_ready(a_if_ready),
    .if_instr(a_if_instr), .if_npc(a_if_npc), .flush(a_flush), .id_ready(a_id_ready),
    .id_valid(a_id_valid), .id_instr(a_id_instr), .id_npc(a_id_npc), .id_op(a_id_op),
    .id_rs(a_id_rs), .id_rt(a_id_rt), .halt_seen(a_halt), .count(a_count)
  );

  if_id_queue #(.XLEN(32), .DEPTH(3), .OPW(4)) dut_b (
    .clk(clk), .reset(b_reset), .if_valid(b_if_valid), .if_ready(b_if_ready),
    .if_instr(b_if_instr), .if_npc(b_if_npc), .flush(b_flush), .id_ready(b_id_ready),
    .id_valid(b_id_valid), .id_instr(b_id_instr), .id_npc(b_id_npc), .id_op(b_id_op),
    .id_rs(b_id_rs), .id_rt(b_id_rt), .halt_seen(b_halt), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] vb [7];
    int ops [14];
    int pi, qi, ec;

    a_reset = 1'b1; a_if_valid = 1'b0; a_if_instr = '0; a_if_npc = '0; a_flush = 1'b0; a_id_ready = 1'b0;
    b_reset = 1'b1; b_if_valid = 1'b0; b_if_instr = '0; b_if_npc = '0; b_flush = 1'b0; b_id_ready = 1'b0;
    tick(); tick();
    a_reset = 1'b0; b_reset = 1'b0;

    // Reset state
    chk("rst_valid", a_id_valid, 0);
    chk("rst_ready", a_if_ready, 1);
    chk("rst_count", a_count, 0);
    chk("rst_instr", a_id_instr, 0);
    chk("rst_npc",   a_id_npc, 0);
    chk("rst_op",    a_id_op, 0);
    chk("rst_halt",  a_halt, 0);

    // Single lw push, visible next cycle
    a_if_valid = 1'b1; a_if_instr = 32'h8C22_0004; a_if_npc = 32'h0000_0104;
    tick();
    a_if_valid = 1'b0;
    chk("lw_valid", a_id_valid, 1);
    chk("lw_op",    a_id_op, 2);
    chk("lw_rs",    a_id_rs, 1);
    chk("lw_rt",    a_id_rt, 2);
    chk("lw_instr", a_id_instr, 32'h8C22_0004);
    chk("lw_npc",   a_id_npc, 32'h0000_0104);
    chk("lw_count", a_count, 1);

    // Fill under stall; third request held off until space appears
    a_if_valid = 1'b1; a_if_instr = 32'h0022_1820; a_if_npc = 32'h0000_0108;
    tick();
    chk("fill_count", a_count, 2);
    chk("fill_ready", a_if_ready, 0);
    chk("fill_head",  a_id_instr, 32'h8C22_0004);
    a_if_instr = 32'hAC43_0008; a_if_npc = 32'h0000_010C;
    tick();
    chk("held_count", a_count, 2);
    a_id_ready = 1'b1;
    tick();
    a_id_ready = 1'b0;
    chk("pop1_count", a_count, 1);
    chk("pop1_instr", a_id_instr, 32'h0022_1820);
    chk("pop1_op",    a_id_op, 8);
    tick();
    a_if_valid = 1'b0;
    chk("late_count", a_count, 2);
    a_id_ready = 1'b1;
    tick();
    chk("sw_count", a_count, 1);
    chk("sw_instr", a_id_instr, 32'hAC43_0008);
    chk("sw_op",    a_id_op, 3);
    chk("sw_rs",    a_id_rs, 2);
    chk("sw_rt",    a_id_rt, 3);
    tick();
    a_id_ready = 1'b0;
    chk("drain_count", a_count, 0);
    chk("drain_valid", a_id_valid, 0);
    chk("drain_instr", a_id_instr, 0);

    // Unlisted R-type funct decodes to 0; flush at count 1 drops a same-cycle push
    a_if_valid = 1'b1; a_if_instr = 32'h0022_1822; a_if_npc = 32'h0000_0200;
    tick();
    chk("sub_valid", a_id_valid, 1);
    chk("sub_op",    a_id_op, 0);
    a_flush = 1'b1; a_if_instr = 32'h1111_1111;
    tick();
    a_flush = 1'b0; a_if_valid = 1'b0;
    chk("fl1_count", a_count, 0);
    chk("fl1_valid", a_id_valid, 0);

    // Streaming push+pop every cycle
    a_if_valid = 1'b1; a_if_instr = 32'h2401_0000; a_if_npc = 32'h0000_0300;
    tick();
    chk("st_op", a_id_op, 7);
    a_id_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      chk("st_head",  a_id_instr, 32'h2401_0000 + 32'(k - 1));
      chk("st_count", a_count, 1);
      a_if_instr = 32'h2401_0000 + 32'(k);
      a_if_npc   = 32'h0000_0300 + 32'(4 * k);
      tick();
    end
    a_if_valid = 1'b0;
    chk("st_last",  a_id_instr, 32'h2401_000A);
    chk("st_lnpc",  a_id_npc, 32'h0000_0328);
    tick();
    a_id_ready = 1'b0;
    chk("st_empty", a_count, 0);

    // Flush at count 2 with a same-cycle push attempt
    a_if_valid = 1'b1; a_if_instr = 32'h1022_0003; a_if_npc = 32'h0000_0400;
    tick();
    a_if_instr = 32'h1422_0003; a_if_npc = 32'h0000_0404;
    tick();
    chk("fl2_pre_count", a_count, 2);
    chk("fl2_pre_op",    a_id_op, 4);
    a_flush = 1'b1; a_if_instr = 32'h2001_0005;
    tick();
    a_flush = 1'b0; a_if_valid = 1'b0;
    chk("fl2_count", a_count, 0);
    chk("fl2_valid", a_id_valid, 0);
    chk("fl2_instr", a_id_instr, 0);
    chk("fl2_npc",   a_id_npc, 0);
    chk("fl2_ready", a_if_ready, 1);

    // Halt: sticky, blocks further pushes, drains as op halt
    a_if_valid = 1'b1; a_if_instr = 32'hFFFF_FFFF; a_if_npc = 32'h0000_0500;
    tick();
    a_if_instr = 32'h2001_0005;
    chk("halt_seen",  a_halt, 1);
    chk("halt_ready", a_if_ready, 0);
    chk("halt_op",    a_id_op, 1);
    chk("halt_count", a_count, 1);
    tick();
    a_if_valid = 1'b0;
    chk("halt_block_count", a_count, 1);
    chk("halt_block_head",  a_id_instr, 32'hFFFF_FFFF);
    a_id_ready = 1'b1;
    tick();
    a_id_ready = 1'b0;
    chk("halt_drain_count", a_count, 0);
    chk("halt_drain_valid", a_id_valid, 0);
    chk("halt_sticky",      a_halt, 1);
    chk("halt_sticky_rdy",  a_if_ready, 0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("halt_clr",     a_halt, 0);
    chk("halt_clr_rdy", a_if_ready, 1);

    // DEPTH=3: interleaved pushes and pops across pointer wrap
    for (int k = 0; k < 7; k++) vb[k] = 32'h8C00_0000 + 32'(k);
    ops = '{1, 1, 1, 2, 2, 1, 1, 2, 2, 2, 1, 1, 2, 2};
    pi = 0; qi = 0; ec = 0;
    for (int i = 0; i < 14; i++) begin
      if (ops[i] == 1) begin
        chk("b_push_ready", b_if_ready, 1);
        b_if_valid = 1'b1; b_if_instr = vb[pi]; b_if_npc = 32'(pi);
        tick();
        b_if_valid = 1'b0;
        pi++; ec++;
      end else begin
        chk("b_pop_instr", b_id_instr, vb[qi]);
        chk("b_pop_npc",   b_id_npc, 32'(qi));
        b_id_ready = 1'b1;
        tick();
        b_id_ready = 1'b0;
        qi++; ec--;
      end
      chk("b_count", b_count, 32'(ec));
      if (ec == 3) chk("b_full_ready", b_if_ready, 0);
    end
    chk("b_empty_valid", b_id_valid, 0);

    // DEPTH=3: reset mid-fill
    b_if_valid = 1'b1; b_if_instr = 32'hAC43_0008; b_if_npc = 32'h0000_0600;
    tick(); tick();
    b_if_valid = 1'b0;
    chk("b_prefill_count", b_count, 2);
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    chk("b_rst_count", b_count, 0);
    chk("b_rst_valid", b_id_valid, 0);
    chk("b_rst_instr", b_id_instr, 0);
    chk("b_rst_npc",   b_id_npc, 0);
    chk("b_rst_op",    b_id_op, 0);
    chk("b_rst_rs",    b_id_rs, 0);
    chk("b_rst_ready", b_if_ready, 1);
    chk("b_rst_halt",  b_halt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
